// File: rtl/calc_ctrl.sv
// Sequences ALU-sample, memory-access and transmitter-load strobes for one calculator command at a time.
// Latency: direct sample@1/load@2, write sample@1/access@2, read access@1/load@3 cycles after the command edge.
// Backpressure: no queueing; commands seen while busy or inactive are dropped and flagged (opt. CALC_CTRL_TIMEOUT_EN).
module calc_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int TX_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              calcActive,
    input  logic              calcMode,
    input  logic              validCmd,
    input  logic              rwMem,
    input  logic [ADDR_W-1:0] addr,
    input  logic              txDone,
    output logic              busy,
    output logic              sampleData,
    output logic              accessMem,
    output logic              rwMemOut,
    output logic [ADDR_W-1:0] memAddr,
    output logic              muxSel,
    output logic              transferData,
    output logic              cmdDropped
`ifdef CALC_CTRL_TIMEOUT_EN
    ,
    output logic              txTimeout
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        WRITE_MEM,
        READ_MEM,
        READ_WAIT,
        TX_LOAD,
        TX_WAIT
    } state_t;

    state_t state;
    state_t nextState;
    logic   acceptCmd;
    logic   cmdWrite;
    logic   cmdRead;

`ifdef CALC_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TX_TIMEOUT + 1);
    logic [CNT_W-1:0] txCnt;
    logic             timeoutHit;
`endif

    always_comb begin
        nextState = state;
        acceptCmd = 1'b0;
`ifdef CALC_CTRL_TIMEOUT_EN
        timeoutHit = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (validCmd && calcActive) begin
                    acceptCmd = 1'b1;
                    nextState = (calcMode && !rwMem) ? READ_MEM : EXEC;
                end
            end
            EXEC:      nextState = cmdWrite ? WRITE_MEM : TX_LOAD;
            WRITE_MEM: nextState = IDLE;
            READ_MEM:  nextState = READ_WAIT;
            READ_WAIT: nextState = TX_LOAD;
            TX_LOAD:   nextState = TX_WAIT;
            TX_WAIT: begin
                if (txDone) begin
                    nextState = IDLE;
`ifdef CALC_CTRL_TIMEOUT_EN
                end else if (txCnt == CNT_W'(TX_TIMEOUT - 1)) begin
                    nextState  = IDLE;
                    timeoutHit = 1'b1;
`endif
                end
            end
            default:   nextState = IDLE;
        endcase
    end

    // Outputs are decoded from nextState so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            sampleData   <= 1'b0;
            accessMem    <= 1'b0;
            rwMemOut     <= 1'b0;
            muxSel       <= 1'b0;
            transferData <= 1'b0;
            cmdDropped   <= 1'b0;
            memAddr      <= '0;
            cmdWrite     <= 1'b0;
            cmdRead      <= 1'b0;
`ifdef CALC_CTRL_TIMEOUT_EN
            txCnt        <= '0;
            txTimeout    <= 1'b0;
`endif
        end else begin
            state        <= nextState;
            busy         <= (nextState != IDLE);
            sampleData   <= (nextState == EXEC);
            accessMem    <= (nextState == WRITE_MEM) || (nextState == READ_MEM);
            rwMemOut     <= (nextState == WRITE_MEM);
            transferData <= (nextState == TX_LOAD);
            muxSel       <= (nextState == READ_WAIT) ||
                            (((nextState == TX_LOAD) || (nextState == TX_WAIT)) && cmdRead);
            cmdDropped   <= validCmd && ((state != IDLE) || !calcActive);
            if (acceptCmd) begin
                memAddr  <= addr;
                cmdWrite <= calcMode && rwMem;
                cmdRead  <= calcMode && !rwMem;
            end
`ifdef CALC_CTRL_TIMEOUT_EN
            if (state == TX_LOAD) begin
                txCnt <= '0;
            end else if (state == TX_WAIT) begin
                txCnt <= txCnt + CNT_W'(1);
            end
            txTimeout <= timeoutHit;
`endif
        end
    end

endmodule

// File: tb/tb_calc_ctrl.sv
// Bench for calc_ctrl: command vector table plus hand sequences, strobes checked against per-kind expectation queues.
module tb_calc_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       calcActive = 1'b0;
    logic       calcMode = 1'b0;
    logic       validCmd = 1'b0;
    logic       rwMem = 1'b0;
    logic [7:0] addr = 8'h00;
    logic       txDone = 1'b0;
    logic       busy, sampleData, accessMem, rwMemOut, muxSel, transferData, cmdDropped;
    logic [7:0] memAddr;
`ifdef CALC_CTRL_TIMEOUT_EN
    logic       txTimeout;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] modelAddr = 8'h00;

    calc_ctrl #(.ADDR_W(8), .TX_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .calcActive(calcActive), .calcMode(calcMode),
        .validCmd(validCmd), .rwMem(rwMem), .addr(addr), .txDone(txDone),
        .busy(busy), .sampleData(sampleData), .accessMem(accessMem), .rwMemOut(rwMemOut),
        .memAddr(memAddr), .muxSel(muxSel), .transferData(transferData), .cmdDropped(cmdDropped)
`ifdef CALC_CTRL_TIMEOUT_EN
        , .txTimeout(txTimeout)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic       rw;
        logic       mux;
        logic [7:0] addr;
        int         cyc;
    } ev_t;

    typedef struct {
        logic       mode;
        logic       rw;
        logic [7:0] addr;
        int         txAt;
        int         dropAt;
        bit         earlyDone;
        bit         dropActive;
    } vec_t;

    ev_t  sampQ[$];
    ev_t  accQ[$];
    ev_t  xferQ[$];
    ev_t  dropQ[$];
    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, got, exp);
        end
    endtask

    task automatic expectEv(input int kind, input logic rw, input logic mux, input logic [7:0] a, input int c);
        ev_t e;
        e.kind = kind; e.rw = rw; e.mux = mux; e.addr = a; e.cyc = c;
        case (kind)
            0: sampQ.push_back(e);
            1: accQ.push_back(e);
            2: xferQ.push_back(e);
            default: dropQ.push_back(e);
        endcase
    endtask

    task automatic observe(input int kind);
        ev_t   e;
        bit    ok;
        string nm;
        ok = 1'b0;
        e  = '{0, 1'b0, 1'b0, 8'h00, 0};
        case (kind)
            0: begin nm = "sampleData";   if (sampQ.size() > 0) begin e = sampQ.pop_front(); ok = 1'b1; end end
            1: begin nm = "accessMem";    if (accQ.size() > 0)  begin e = accQ.pop_front();  ok = 1'b1; end end
            2: begin nm = "transferData"; if (xferQ.size() > 0) begin e = xferQ.pop_front(); ok = 1'b1; end end
            default: begin nm = "cmdDropped"; if (dropQ.size() > 0) begin e = dropQ.pop_front(); ok = 1'b1; end end
        endcase
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: unexpected strobe at cycle %0d", nm, cyc);
        end else if (e.cyc != cyc || memAddr !== e.addr ||
                     (kind == 1 && rwMemOut !== e.rw) || (kind == 2 && muxSel !== e.mux)) begin
            errors++;
            $display("FAIL %s: got cyc=%0d memAddr=%h rw=%b mux=%b, want cyc=%0d memAddr=%h rw=%b mux=%b",
                     nm, cyc, memAddr, rwMemOut, muxSel, e.cyc, e.addr, e.rw, e.mux);
        end
    endtask

    always @(negedge clk) begin
        if (sampleData === 1'b1)   observe(0);
        if (accessMem === 1'b1)    observe(1);
        if (transferData === 1'b1) observe(2);
        if (cmdDropped === 1'b1)   observe(3);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCyc(input int t);
        while (cyc < t) tick();
    endtask

    task automatic runCmd(input vec_t v);
        int E;
        calcActive = 1'b1; calcMode = v.mode; rwMem = v.rw; addr = v.addr; validCmd = 1'b1;
        tick();
        E = cyc;
        // Scramble inputs so any use of unlatched values shows up.
        validCmd = 1'b0; addr = ~v.addr; rwMem = ~v.rw; calcMode = ~v.mode;
        if (v.dropActive) calcActive = 1'b0;
        modelAddr = v.addr;
        if (!v.mode) begin
            expectEv(0, 1'b0, 1'b0, v.addr, E);
            expectEv(2, 1'b0, 1'b0, v.addr, E + 1);
        end else if (v.rw) begin
            expectEv(0, 1'b0, 1'b0, v.addr, E);
            expectEv(1, 1'b1, 1'b0, v.addr, E + 1);
        end else begin
            expectEv(1, 1'b0, 1'b0, v.addr, E);
            expectEv(2, 1'b0, 1'b1, v.addr, E + 2);
        end
        check("busy after accept", 32'(busy), 32'd1);
        if (v.mode && v.rw) begin
            waitCyc(E + 2);
            check("busy released after write", 32'(busy), 32'd0);
        end else begin
            if (v.earlyDone) begin
                waitCyc(E + (v.mode ? 2 : 1));
                txDone = 1'b1;
                tick();
                txDone = 1'b0;
                check("txDone in TX_LOAD ignored", 32'(busy), 32'd1);
            end
            if (v.dropAt > 0) begin
                waitCyc(E + v.dropAt - 1);
                validCmd = 1'b1; addr = 8'hEE;
                expectEv(3, 1'b0, 1'b0, v.addr, E + v.dropAt);
                tick();
                validCmd = 1'b0;
                check("busy after dropped cmd", 32'(busy), 32'd1);
            end
            waitCyc(E + v.txAt - 1);
            check("busy before txDone", 32'(busy), 32'd1);
            txDone = 1'b1;
            tick();
            txDone = 1'b0;
            check("busy after txDone", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int E;
        //             mode  rw    addr   txAt drop early inact
        vecs[0] = '{1'b0, 1'b0, 8'h01, 20, 0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 8'h05, 0,  0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 8'h05, 8,  5, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 8'hA5, 3,  0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 8'hFF, 0,  0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 8'h00, 4,  2, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 8'h3C, 7,  3, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 8'h11, 6,  0, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 8'h5A, 9,  0, 1'b1, 1'b0};

        // Reset held with a command strobe present.
        reset = 1'b0; calcActive = 1'b1; validCmd = 1'b1; addr = 8'h33;
        tick();
        tick();
        check("reset strobes", 32'({busy, sampleData, accessMem, rwMemOut, muxSel, transferData, cmdDropped}), 32'd0);
        check("reset memAddr", 32'(memAddr), 32'd0);
        validCmd = 1'b0; reset = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) runCmd(vecs[i]);

        // Commands while inactive in IDLE, held for two samples.
        calcActive = 1'b0; calcMode = 1'b0; validCmd = 1'b1; addr = 8'h99;
        expectEv(3, 1'b0, 1'b0, modelAddr, cyc + 1);
        expectEv(3, 1'b0, 1'b0, modelAddr, cyc + 2);
        tick();
        check("busy inactive drop 1", 32'(busy), 32'd0);
        tick();
        validCmd = 1'b0;
        check("busy inactive drop 2", 32'(busy), 32'd0);
        tick();
        check("busy inactive after", 32'(busy), 32'd0);

        // Reset during READ_WAIT: no transmit load may follow.
        calcActive = 1'b1; calcMode = 1'b1; rwMem = 1'b0; addr = 8'h77; validCmd = 1'b1;
        tick();
        E = cyc;
        validCmd = 1'b0;
        modelAddr = 8'h77;
        expectEv(1, 1'b0, 1'b0, 8'h77, E);
        waitCyc(E + 1);
        reset = 1'b0;
        tick();
        check("busy after mid reset", 32'(busy), 32'd0);
        check("transferData after mid reset", 32'(transferData), 32'd0);
        check("memAddr after mid reset", 32'(memAddr), 32'd0);
        reset = 1'b1;
        modelAddr = 8'h00;
        repeat (6) tick();

`ifdef CALC_CTRL_TIMEOUT_EN
        calcActive = 1'b1; calcMode = 1'b0; rwMem = 1'b0; addr = 8'h42; validCmd = 1'b1;
        tick();
        E = cyc;
        validCmd = 1'b0;
        modelAddr = 8'h42;
        expectEv(0, 1'b0, 1'b0, 8'h42, E);
        expectEv(2, 1'b0, 1'b0, 8'h42, E + 1);
        waitCyc(E + 16);
        check("timeout not yet", 32'({txTimeout, busy}), 32'b01);
        tick();
        check("timeout pulse", 32'({txTimeout, busy}), 32'b10);
        tick();
        check("timeout one cycle", 32'({txTimeout, busy}), 32'b00);
`endif

        repeat (3) tick();
        check("expectation queues drained", 32'(sampQ.size() + accQ.size() + xferQ.size() + dropQ.size()), 32'd0);
        check("final busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc_ctrl.md
Name: calc_ctrl

Overview:
- Control sequencer for the calculator datapath: ALU, 256x32 register memory and serial transmitter with clock divider.
- Accepts one command per validCmd pulse while calcActive is high.
- Issues the ALU-sample, memory-access and transmitter-load strobes in the correct order, then holds busy until the transmitter reports completion.
- Sits between the top-level command inputs and the datapath, replacing ad-hoc control glue.

Parameters:
- ADDR_W, 8: width of memory address latched per command.
- TX_TIMEOUT, 1023: cycles allowed in TX_WAIT before abort (only with CALC_CTRL_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous active-low reset; low at a rising clk edge clears all state.
- calcActive  input  1  calculator enabled; commands accepted only when 1.
- calcMode  input  1  0 = direct (ALU result to transmitter), 1 = memory mode.
- validCmd  input  1  command strobe, sampled in IDLE only.
- rwMem  input  1  memory mode only: 1 = write ALU result to memory, 0 = read memory and transmit.
- addr  input  ADDR_W  command address.
- txDone  input  1  one-cycle pulse from serializer when the last bit is sent.
- busy  output  1  1 whenever state != IDLE.
- sampleData  output  1  one-cycle strobe: capture ALU result into result register.
- accessMem  output  1  memory enable, one cycle.
- rwMemOut  output  1  memory write enable, qualified by accessMem.
- memAddr  output  ADDR_W  latched command address.
- muxSel  output  1  transmitter source: 0 = ALU result register, 1 = memory read data.
- transferData  output  1  one-cycle strobe: load transmitter shift register.
- cmdDropped  output  1  one-cycle pulse: validCmd arrived while busy or while calcActive = 0.

Behaviour:
- States: IDLE, EXEC, WRITE_MEM, READ_MEM, READ_WAIT, TX_LOAD, TX_WAIT. Encoding is free.
- All outputs are Moore-decoded from the state register, except cmdDropped (registered) and memAddr (registered).
- Reset: state = IDLE; all outputs 0; memAddr = 0.
- Command acceptance in IDLE: when validCmd && calcActive, latch addr into memAddr and go to:
  - EXEC if calcMode = 0, or if calcMode = 1 with rwMem = 1;
  - READ_MEM if calcMode = 1 with rwMem = 0.
  - The rwMem value is latched at acceptance and used for the whole command.
- EXEC: sampleData = 1. Next state is TX_LOAD in direct mode, WRITE_MEM in write mode.
- WRITE_MEM: accessMem = 1, rwMemOut = 1. Then IDLE.
- READ_MEM: accessMem = 1, rwMemOut = 0. Then READ_WAIT, which covers the memory's 1-cycle read latency.
- READ_WAIT: muxSel = 1. Then TX_LOAD.
- TX_LOAD: transferData = 1; muxSel = 1 if the command was a read, else 0. Then TX_WAIT.
- TX_WAIT: muxSel holds. Stay until txDone = 1, then IDLE.
- Latency, counted from the edge that samples validCmd (cycle 0):
  - direct: sampleData in cycle 1, transferData in cycle 2;
  - write: sampleData in cycle 1, accessMem in cycle 2, busy = 0 in cycle 3;
  - read: accessMem in cycle 1, transferData in cycle 3.
- A new command can be accepted in the first cycle after returning to IDLE. There is no queueing.
- cmdDropped pulses the cycle after a validCmd that is sampled under either of these conditions:
  - state != IDLE;
  - state = IDLE with calcActive = 0.
  - validCmd held high is counted every cycle it is sampled under those conditions.
- calcActive falling mid-command: the current command runs to completion.
- txDone outside TX_WAIT: ignored.
- txDone in the same cycle as TX_LOAD: ignored; TX_WAIT is still entered.
- reset low mid-command: IDLE and all outputs 0 on the next edge. No memory write is issued after that edge.

Optional Feature:
- Macro CALC_CTRL_TIMEOUT_EN.
- Defined:
  - adds a 10-bit (clog2 of TX_TIMEOUT+1) counter, cleared on TX_WAIT entry and incremented each cycle in TX_WAIT;
  - when the counter reaches TX_TIMEOUT without txDone, go to IDLE and pulse output txTimeout for one cycle;
  - txDone and timeout in the same cycle: txDone wins and txTimeout stays 0.
- Undefined: no counter and no txTimeout port; TX_WAIT waits indefinitely.

Test Plan:
- Reset: reset = 0 for 2 cycles with validCmd = 1 -> busy = 0, all strobes 0, memAddr = 0.
- Direct: calcActive = 1, calcMode = 0, validCmd for 1 cycle, addr = 8'h01 -> sampleData in cycle 1, transferData with muxSel = 0 in cycle 2; busy held until txDone injected at cycle 20, then busy = 0 at cycle 21.
- Memory write then read:
  - calcMode = 1, rwMem = 1, addr = 8'h05 -> accessMem = 1, rwMemOut = 1, memAddr = 8'h05 in cycle 2.
  - Then rwMem = 0 on the same address -> accessMem = 1, rwMemOut = 0 in cycle 1; transferData with muxSel = 1 in cycle 3.
- Dropped commands:
  - validCmd pulses while in TX_WAIT -> cmdDropped pulses; state and memAddr unchanged.
  - validCmd with calcActive = 0 in IDLE -> cmdDropped pulses; busy stays 0.
- Reset mid-op: reset = 0 during READ_WAIT -> next cycle busy = 0, transferData never asserted.
- Timeout, with macro defined and TX_TIMEOUT = 15: no txDone -> txTimeout pulses 15 cycles after TX_WAIT entry, then IDLE.
